// File: rtl/hyperbus_cfg_boot.sv
// Boot sequencer in front of the HyperBus controller's config register port:
// after a start delay it writes a fixed table of config words, then passes the host bus through.
module hyperbus_cfg_boot #(
    parameter int unsigned NumEntries   = 4,
    parameter int unsigned RegAddrWidth = 32,
    parameter int unsigned RegDataWidth = 32,
    parameter type reg_req_t = struct packed {
        logic [RegAddrWidth-1:0]   addr;
        logic                      write;
        logic [RegDataWidth-1:0]   wdata;
        logic [RegDataWidth/8-1:0] wstrb;
        logic                      valid;
    },
    parameter type reg_rsp_t = struct packed {
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
        logic                    ready;
    },
    parameter logic [NumEntries-1:0][RegAddrWidth-1:0] BootAddr = '0,
    parameter logic [NumEntries-1:0][RegDataWidth-1:0] BootData = '0,
    parameter int unsigned StartDelay = 16,
    parameter int unsigned MaxRetries = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        restart_i,
    input  reg_req_t                    ext_req_i,
    output reg_rsp_t                    ext_rsp_o,
    output reg_req_t                    hyper_req_o,
    input  reg_rsp_t                    hyper_rsp_i,
    output logic                        boot_done_o,
    output logic                        boot_error_o,
    output logic [$clog2(NumEntries):0] err_idx_o
);

    localparam int unsigned DlyW   = (StartDelay > 0) ? $clog2(StartDelay + 1) : 1;
    localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam int unsigned IdxW   = (NumEntries > 1) ? $clog2(NumEntries) : 1;
    localparam int unsigned ErrW   = $clog2(NumEntries) + 1;

    localparam logic [DlyW-1:0]   DlyLast  = (StartDelay > 0) ? DlyW'(StartDelay - 1) : '0;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetries);
    localparam logic [IdxW-1:0]   IdxLast  = IdxW'(NumEntries - 1);

    typedef enum logic [1:0] {
        StWait,
        StWrite,
        StRetry,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DlyW-1:0]   dly_q, dly_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              err_q, err_d;
    logic [ErrW-1:0]   err_idx_q, err_idx_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StWait;
            dly_q     <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '1;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        retry_d     = retry_q;
        idx_d       = idx_q;
        err_d       = err_q;
        err_idx_d   = err_idx_q;
        hyper_req_o = '0;
        ext_rsp_o   = '0;

        unique case (state_q)
            StWait: begin
                if (StartDelay == 0 || dly_q == DlyLast) begin
                    state_d = StWrite;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StWrite: begin
                hyper_req_o.valid = 1'b1;
                hyper_req_o.write = 1'b1;
                hyper_req_o.addr  = BootAddr[idx_q];
                hyper_req_o.wdata = BootData[idx_q];
                hyper_req_o.wstrb = '1;
                if (hyper_rsp_i.ready) begin
                    if (hyper_rsp_i.error && retry_q < RetryMax) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StRetry;
                    end else begin
                        // An exhausted entry is recorded but the table still advances.
                        if (hyper_rsp_i.error) begin
                            err_d = 1'b1;
                            if (err_idx_q == '1) begin
                                err_idx_d = ErrW'(idx_q);
                            end
                        end
                        retry_d = '0;
                        if (idx_q == IdxLast) begin
                            state_d = StDone;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            StRetry: begin
                state_d = StWrite;
            end
            StDone: begin
                hyper_req_o = ext_req_i;
                ext_rsp_o   = hyper_rsp_i;
                // Restart is deferred while a host access is open so it is never torn.
                if (restart_i && !ext_req_i.valid) begin
                    state_d   = StWait;
                    dly_d     = '0;
                    retry_d   = '0;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    err_idx_d = '1;
                end
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    assign boot_done_o  = (state_q == StDone);
    assign boot_error_o = err_q;
    assign err_idx_o    = err_idx_q;

endmodule

// File: tb/tb_hyperbus_cfg_boot.sv
// Directed bench for hyperbus_cfg_boot: scripted slave with stalls/errors, host pass-through,
// restart and mid-sequence reset.
module tb_hyperbus_cfg_boot;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_t;

    localparam logic [3:0][31:0] BootAddrTb = {32'h0000_010C, 32'h0000_0108, 32'h0000_0104, 32'h0000_0100};
    localparam logic [3:0][31:0] BootDataTb = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};

    logic       clk;
    logic       rstN;
    logic       restart;
    req_t       extReq;
    rsp_t       extRsp;
    req_t       hyperReq;
    rsp_t       hyperRsp;
    logic       bootDone;
    logic       bootError;
    logic [2:0] errIdx;

    int nChecks = 0;
    int nBad    = 0;

    // Slave model state: per-entry attempt counts and stall counts only ever grow; tests use bases.
    int attempts [4] = '{0, 0, 0, 0};
    int attBase  [4] = '{0, 0, 0, 0};
    int errPlan  [4] = '{0, 0, 0, 0};
    int stallCnt     = 0;
    int stallBase    = 0;
    int stallPlan    = 0;
    int stallEntry   = -1;
    int stableBad    = 0;
    int cycAbs       = 0;
    int cycBase      = 0;
    int hsStart      = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevAddr  = '0;
    logic [31:0] prevData  = '0;
    logic [31:0] hsAddr [$];
    logic [31:0] hsData [$];
    int          hsCyc  [$];

    hyperbus_cfg_boot #(
        .NumEntries  (4),
        .RegAddrWidth(32),
        .RegDataWidth(32),
        .reg_req_t   (req_t),
        .reg_rsp_t   (rsp_t),
        .BootAddr    (BootAddrTb),
        .BootData    (BootDataTb),
        .StartDelay  (16),
        .MaxRetries  (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .restart_i   (restart),
        .ext_req_i   (extReq),
        .ext_rsp_o   (extRsp),
        .hyper_req_o (hyperReq),
        .hyper_rsp_i (hyperRsp),
        .boot_done_o (bootDone),
        .boot_error_o(bootError),
        .err_idx_o   (errIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int entryOf(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a == BootAddrTb[i]) return i;
        end
        return -1;
    endfunction

    // Config-register slave: always ready unless a stall is scripted, errors per entry plan.
    always_comb begin
        int e;
        hyperRsp       = '0;
        hyperRsp.rdata = 32'hCAFE_F00D;
        hyperRsp.ready = 1'b1;
        e = entryOf(hyperReq.addr);
        if (hyperReq.valid && e >= 0) begin
            if (e == stallEntry && (stallCnt - stallBase) < stallPlan) hyperRsp.ready = 1'b0;
            if ((attempts[e] - attBase[e]) < errPlan[e]) hyperRsp.error = 1'b1;
        end
    end

    // Handshake logger and payload-stability watcher.
    always @(posedge clk) begin
        int e;
        cycAbs <= cycAbs + 1;
        if (hyperReq.valid && hyperRsp.ready) begin
            hsAddr.push_back(hyperReq.addr);
            hsData.push_back(hyperReq.wdata);
            hsCyc.push_back(cycAbs + 1);
            e = entryOf(hyperReq.addr);
            if (e >= 0) attempts[e] <= attempts[e] + 1;
        end
        if (hyperReq.valid && !hyperRsp.ready) begin
            stallCnt <= stallCnt + 1;
            if (prevStall && (hyperReq.addr != prevAddr || hyperReq.wdata != prevData))
                stableBad <= stableBad + 1;
        end
        prevStall <= hyperReq.valid && !hyperRsp.ready;
        prevAddr  <= hyperReq.addr;
        prevData  <= hyperReq.wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rs, input req_t req);
        rstN    = rst;
        restart = rs;
        extReq  = req;
    endtask

    task automatic startWindow();
        cycBase   = cycAbs;
        hsStart   = hsAddr.size();
        stallBase = stallCnt;
        for (int i = 0; i < 4; i++) attBase[i] = attempts[i];
    endtask

    task automatic doReset(input int errA, input int errB, input int errC, input int errD,
                           input int stEnt, input int stNum);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0);
        errPlan    = '{errA, errB, errC, errD};
        stallEntry = stEnt;
        stallPlan  = stNum;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 32'(hyperReq.valid), 32'd0);
        checkOutput("rst_extready", 32'(extRsp.ready), 32'd0);
        checkOutput("rst_done", 32'(bootDone), 32'd0);
        checkOutput("rst_err", 32'(bootError), 32'd0);
        checkOutput("rst_erridx", 32'(errIdx), 32'd7);
        rstN = 1'b1;
        startWindow();
    endtask

    // Runs until boot_done_o rises or a cycle budget expires; cycles are relative to the window.
    task automatic runBoot(output int firstV, output int doneC, output int extBad);
        firstV = -1;
        doneC  = -1;
        extBad = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (hyperReq.valid && firstV < 0 && !bootDone) firstV = cycAbs - cycBase;
            if (bootDone) begin
                doneC = cycAbs - cycBase;
                break;
            end
            if (extRsp.ready || extRsp.error) extBad++;
        end
        if (doneC < 0) checkOutput("boot_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] hsRelCyc(input int k);
        if (hsStart + k >= hsCyc.size()) return 32'hFFFF_FFFF;
        return 32'(hsCyc[hsStart + k] - cycBase);
    endfunction

    function automatic logic [31:0] hsAddrAt(input int k);
        if (hsStart + k >= hsAddr.size()) return 32'hFFFF_FFFF;
        return hsAddr[hsStart + k];
    endfunction

    initial begin
        int   fv, dc, eb, sb;
        req_t hostReq;
        int   expCyc3 [6];
        int   expCyc4 [8];
        logic [31:0] expAddr4 [8];

        applyStimulus(1'b0, 1'b0, '0);

        // Clean boot: timing of first write, write order, done timing.
        doReset(0, 0, 0, 0, -1, 0);
        runBoot(fv, dc, eb);
        checkOutput("t1_first_valid", 32'(fv), 32'd16);
        checkOutput("t1_hs_count", 32'(hsAddr.size() - hsStart), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1_addr%0d", i), hsAddrAt(i), BootAddrTb[i]);
            checkOutput($sformatf("t1_cyc%0d", i), hsRelCyc(i), 32'(17 + i));
            if (hsStart + i < hsData.size())
                checkOutput($sformatf("t1_data%0d", i), hsData[hsStart + i], BootDataTb[i]);
        end
        checkOutput("t1_done_cyc", 32'(dc), 32'd20);
        checkOutput("t1_err", 32'(bootError), 32'd0);
        checkOutput("t1_erridx", 32'(errIdx), 32'd7);

        // Three wait cycles on entry 1.
        doReset(0, 0, 0, 0, 1, 3);
        sb = stableBad;
        runBoot(fv, dc, eb);
        checkOutput("t2_hs_count", 32'(hsAddr.size() - hsStart), 32'd4);
        checkOutput("t2_stalls", 32'(stallCnt - stallBase), 32'd3);
        checkOutput("t2_stable", 32'(stableBad - sb), 32'd0);
        checkOutput("t2_cyc1", hsRelCyc(1), 32'd21);
        checkOutput("t2_addr1", hsAddrAt(1), BootAddrTb[1]);
        checkOutput("t2_done_cyc", 32'(dc), 32'd23);

        // Entry 2 errors twice then succeeds.
        doReset(0, 0, 2, 0, -1, 0);
        runBoot(fv, dc, eb);
        expCyc3 = '{17, 18, 19, 21, 23, 24};
        checkOutput("t3_hs_count", 32'(hsAddr.size() - hsStart), 32'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("t3_cyc%0d", i), hsRelCyc(i), 32'(expCyc3[i]));
        for (int i = 2; i < 5; i++) checkOutput($sformatf("t3_addr%0d", i), hsAddrAt(i), BootAddrTb[2]);
        checkOutput("t3_done_cyc", 32'(dc), 32'd24);
        checkOutput("t3_err", 32'(bootError), 32'd0);
        checkOutput("t3_erridx", 32'(errIdx), 32'd7);

        // Entries 1 and 3 always error: retries exhausted on both, first failure recorded.
        doReset(0, 99, 0, 99, -1, 0);
        runBoot(fv, dc, eb);
        expCyc4  = '{17, 18, 20, 22, 23, 24, 26, 28};
        expAddr4 = '{BootAddrTb[0], BootAddrTb[1], BootAddrTb[1], BootAddrTb[1],
                     BootAddrTb[2], BootAddrTb[3], BootAddrTb[3], BootAddrTb[3]};
        checkOutput("t4_hs_count", 32'(hsAddr.size() - hsStart), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t4_cyc%0d", i), hsRelCyc(i), 32'(expCyc4[i]));
            checkOutput($sformatf("t4_addr%0d", i), hsAddrAt(i), expAddr4[i]);
        end
        checkOutput("t4_done_cyc", 32'(dc), 32'd28);
        checkOutput("t4_err", 32'(bootError), 32'd1);
        checkOutput("t4_erridx", 32'(errIdx), 32'd1);

        // Restart from DONE with host idle: error state clears, whole table repeats.
        errPlan = '{0, 0, 0, 0};
        applyStimulus(1'b1, 1'b1, '0);
        startWindow();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("t5_done_drop", 32'(bootDone), 32'd0);
        checkOutput("t5_err_clr", 32'(bootError), 32'd0);
        checkOutput("t5_erridx_clr", 32'(errIdx), 32'd7);
        runBoot(fv, dc, eb);
        checkOutput("t5_first_valid", 32'(fv), 32'd17);
        checkOutput("t5_hs_count", 32'(hsAddr.size() - hsStart), 32'd4);
        checkOutput("t5_addr0", hsAddrAt(0), BootAddrTb[0]);
        checkOutput("t5_addr3", hsAddrAt(3), BootAddrTb[3]);
        checkOutput("t5_done_cyc", 32'(dc), 32'd21);

        // Restart while a host access is open is ignored.
        hostReq       = '0;
        hostReq.valid = 1'b1;
        hostReq.write = 1'b1;
        hostReq.addr  = 32'h0000_0300;
        applyStimulus(1'b1, 1'b1, hostReq);
        @(negedge clk);
        checkOutput("t6_done_hold", 32'(bootDone), 32'd1);
        applyStimulus(1'b1, 1'b0, hostReq);
        @(negedge clk);
        checkOutput("t6_done_hold2", 32'(bootDone), 32'd1);
        checkOutput("t6_pass_addr", hyperReq.addr, 32'h0000_0300);
        applyStimulus(1'b1, 1'b0, '0);

        // Host access during boot is stalled, then completes combinationally in DONE.
        doReset(0, 0, 0, 0, -1, 0);
        repeat (5) @(negedge clk);
        hostReq       = '0;
        hostReq.valid = 1'b1;
        hostReq.addr  = 32'h0000_0200;
        applyStimulus(1'b1, 1'b0, hostReq);
        runBoot(fv, dc, eb);
        checkOutput("t7_ext_stalled", 32'(eb), 32'd0);
        checkOutput("t7_done_cyc", 32'(dc), 32'd20);
        checkOutput("t7_hs_count", 32'(hsAddr.size() - hsStart), 32'd4);
        checkOutput("t7_ext_ready", 32'(extRsp.ready), 32'd1);
        checkOutput("t7_ext_rdata", extRsp.rdata, 32'hCAFE_F00D);
        checkOutput("t7_pass_addr", hyperReq.addr, 32'h0000_0200);
        checkOutput("t7_pass_write", 32'(hyperReq.write), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0);

        // Reset asserted mid-entry-2 drops valid at once; sequence restarts from entry 0.
        doReset(0, 0, 0, 0, -1, 0);
        repeat (18) @(negedge clk);
        checkOutput("t8_pre_valid", 32'(hyperReq.valid), 32'd1);
        checkOutput("t8_pre_addr", hyperReq.addr, BootAddrTb[2]);
        #1 rstN = 1'b0;
        #1 checkOutput("t8_async_valid", 32'(hyperReq.valid), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        startWindow();
        runBoot(fv, dc, eb);
        checkOutput("t8_first_valid", 32'(fv), 32'd16);
        checkOutput("t8_addr0", hsAddrAt(0), BootAddrTb[0]);
        checkOutput("t8_cyc0", hsRelCyc(0), 32'd17);
        checkOutput("t8_done_cyc", 32'(dc), 32'd20);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
